host_polinomio: RTL and testbench
=================================

// Module: host_polinomio
// PURPOSE
//  Host sequencer on the initiator side of the polynomial datapath (projeto) handshake.
//  - Sweeps X from x_ini to x_fim.
//  - For each X: presents operands, pulses inicio, waits for LED, captures Resultado, pulses pronto.
//  - Streams each (X, Resultado) pair to the consumer and flags a stalled datapath.
// PARAMETERS
//  W        16  operand/result width (X, A, B, C, Resultado)
//  TIMEOUT  64  max cycles in ESPERA or LIBERA before erro is raised; legal range 2..2^16
// PORTS
//  ck          in   1    clock, rising edge
//  rst         in   1    asynchronous reset, ACTIVE-LOW (0 = reset)
//  comeca      in   1    sweep request, sampled only in OCIOSO
//  x_ini       in   W    first X of sweep
//  x_fim       in   W    last X of sweep (inclusive)
//  a_in,b_in,c_in in W   coefficients, latched on sweep start
//  inicio      out  1    to datapath: start one evaluation
//  pronto      out  1    to datapath: result consumed
//  X,A,B,C     out  W    to datapath: operands, stable from DISPARA through LIBERA
//  Resultado   in   W    from datapath: valid while LED=1
//  LED         in   1    from datapath: result ready
//  res_valido  out  1    1-cycle strobe: res_x/res_val valid
//  res_x       out  W    X of the captured result
//  res_val     out  W    captured Resultado
//  ocupado     out  1    1 in any state except OCIOSO
//  terminou    out  1    1-cycle strobe at sweep end, success or error
//  erro        out  1    sticky timeout flag; cleared on next accepted comeca
//  contagem    out  W+1  results captured in the current or last sweep
// BEHAVIOUR
//  Reset (rst=0, async): state=OCIOSO.
//   - All outputs 0: inicio, pronto, X, A, B, C, res_*, terminou, erro, contagem.
//  States and transitions:
//  - OCIOSO: wait for comeca=1.
//  - CARREGA: latch a/b/c_in into A/B/C; X<=x_ini; erro<=0; contagem<=0.
//   - If x_ini>x_fim (unsigned): go to FIM; zero evaluations, no inicio.
//   - Otherwise go to DISPARA.
//  - DISPARA: inicio=1 for exactly this one cycle; go to ESPERA; timer cleared.
//  - ESPERA: wait for LED=1.
//   - LED=1: go to CAPTURA.
//   - Timer reaches TIMEOUT-1 with LED=0: erro<=1, go to ERRO.
//  - CAPTURA (one cycle):
//   - res_val<=Resultado; res_x<=X; res_valido=1; pronto=1; contagem+=1.
//   - Go to LIBERA; timer cleared.
//  - LIBERA: wait for LED=0.
//   - LED=0 and X==x_fim: go to FIM.
//   - LED=0 and X!=x_fim: X<=X+1, go to DISPARA.
//   - TIMEOUT with LED still 1: erro<=1, go to ERRO.
//  - ERRO: pronto=1 for one cycle to clear the datapath, then go to FIM.
//  - FIM: terminou=1 for one cycle, then go to OCIOSO.
//   - X/A/B/C and res_* hold their values until the next sweep.
//  Latency: DISPARA to CAPTURA = 2 + (cycles LED stays 0 after inicio).
//  Registered outputs: inicio, pronto, res_valido and terminou are registered.
//   - Each is 1 in the cycle after the state is entered.
//   - Each is never high for 2 consecutive cycles.
//  Width and boundary rules:
//  - x_fim comparison is done before increment, so x_fim=2^W-1 ends without X wrap.
//   - Full sweep 0..2^W-1 gives contagem=2^W, hence W+1 bits.
//  - x_ini==x_fim: exactly one evaluation.
//  - comeca while ocupado=1: ignored. comeca held high after FIM: a new sweep starts.
//  - LED already 1 on entry to ESPERA: captured at the next edge; no dependence on an inicio edge.
//  - Reset mid-sweep: immediate return to OCIOSO; inicio/pronto drop the same instant.
// TESTING
//  Bench contains a behavioural projeto: Resultado=A*X*X+B*X+C; LED set N cycles after inicio;
//  LED cleared on pronto.
//  1. A=1,B=3,C=4, x_ini=x_fim=2, N=3 -> single res_valido with res_x=2, res_val=14;
//     terminou; contagem=1; erro=0.
//  2. Same coefficients, x_ini=0, x_fim=3 -> res_val sequence 4,8,14,22; exactly 4 inicio
//     pulses; contagem=4.
//  3. x_ini=5, x_fim=2 -> no inicio; terminou 2 cycles after comeca; contagem=0.
//  4. Model never raises LED, TIMEOUT=64 -> erro=1 64 cycles into ESPERA; one pronto;
//     terminou; no res_valido.
//  5. x_ini=16'hFFFE, x_fim=16'hFFFF, A=0,B=1,C=0 -> results 16'hFFFE, 16'hFFFF;
//     X does not wrap; contagem=2.
//  6. rst=0 during ESPERA of case 2 -> outputs 0 with no clock edge; later comeca sweeps
//     cleanly from x_ini.

Source files
------------

// File: rtl/host_polinomio.sv
// Initiator-side sequencer for the polynomial datapath: sweeps X over [x_ini, x_fim],
// runs one inicio/LED/pronto handshake per point and streams each (X, Resultado) pair out.
module host_polinomio #(
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         comeca,
    input  logic [W-1:0] x_ini,
    input  logic [W-1:0] x_fim,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic [W-1:0] c_in,
    output logic         inicio,
    output logic         pronto,
    output logic [W-1:0] X,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic [W-1:0] C,
    input  logic [W-1:0] Resultado,
    input  logic         LED,
    output logic         res_valido,
    output logic [W-1:0] res_x,
    output logic [W-1:0] res_val,
    output logic         ocupado,
    output logic         terminou,
    output logic         erro,
    output logic [W:0]   contagem
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        OCIOSO, CARREGA, DISPARA, ESPERA, CAPTURA, LIBERA, ERRO, FIM
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [W-1:0]  x_q, x_d, a_q, a_d, b_q, b_d, c_q, c_d, xfim_q, xfim_d;
    logic [W-1:0]  res_x_q, res_x_d, res_val_q, res_val_d;
    logic [W:0]    contagem_q, contagem_d;
    logic          erro_q, erro_d;
    logic          inicio_q, inicio_d, pronto_q, pronto_d;
    logic          res_valido_q, res_valido_d, terminou_q, terminou_d;

    // Next-state, datapath updates and one-cycle strobes derived from the state being entered
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        x_d        = x_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        xfim_d     = xfim_q;
        res_x_d    = res_x_q;
        res_val_d  = res_val_q;
        contagem_d = contagem_q;
        erro_d     = erro_q;
        case (state_q)
            OCIOSO: begin
                if (comeca) begin
                    state_d    = CARREGA;
                    a_d        = a_in;
                    b_d        = b_in;
                    c_d        = c_in;
                    x_d        = x_ini;
                    xfim_d     = x_fim;
                    erro_d     = 1'b0;
                    contagem_d = '0;
                end else begin
                    state_d = OCIOSO;
                end
            end
            CARREGA: begin
                if (x_q > xfim_q) begin
                    state_d = FIM;
                end else begin
                    state_d = DISPARA;
                end
            end
            DISPARA: begin
                state_d = ESPERA;
                timer_d = '0;
            end
            ESPERA: begin
                if (LED) begin
                    state_d    = CAPTURA;
                    res_val_d  = Resultado;
                    res_x_d    = x_q;
                    contagem_d = contagem_q + {{W{1'b0}}, 1'b1};
                end else if (timer_q == TMAX) begin
                    state_d = ERRO;
                    erro_d  = 1'b1;
                end else begin
                    timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            CAPTURA: begin
                state_d = LIBERA;
                timer_d = '0;
            end
            LIBERA: begin
                // The end test precedes the increment so x_fim = all-ones never wraps X
                if (!LED) begin
                    if (x_q == xfim_q) begin
                        state_d = FIM;
                    end else begin
                        x_d     = x_q + {{(W-1){1'b0}}, 1'b1};
                        state_d = DISPARA;
                    end
                end else if (timer_q == TMAX) begin
                    state_d = ERRO;
                    erro_d  = 1'b1;
                end else begin
                    timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            ERRO:    state_d = FIM;
            FIM:     state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase
        inicio_d     = (state_d == DISPARA);
        pronto_d     = (state_d == CAPTURA) || (state_d == ERRO);
        res_valido_d = (state_d == CAPTURA);
        terminou_d   = (state_d == FIM);
    end

    // State and output registers; reset clears every output immediately
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q      <= OCIOSO;
            timer_q      <= '0;
            x_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            xfim_q       <= '0;
            res_x_q      <= '0;
            res_val_q    <= '0;
            contagem_q   <= '0;
            erro_q       <= 1'b0;
            inicio_q     <= 1'b0;
            pronto_q     <= 1'b0;
            res_valido_q <= 1'b0;
            terminou_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            x_q          <= x_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            xfim_q       <= xfim_d;
            res_x_q      <= res_x_d;
            res_val_q    <= res_val_d;
            contagem_q   <= contagem_d;
            erro_q       <= erro_d;
            inicio_q     <= inicio_d;
            pronto_q     <= pronto_d;
            res_valido_q <= res_valido_d;
            terminou_q   <= terminou_d;
        end
    end

    assign inicio     = inicio_q;
    assign pronto     = pronto_q;
    assign X          = x_q;
    assign A          = a_q;
    assign B          = b_q;
    assign C          = c_q;
    assign res_valido = res_valido_q;
    assign res_x      = res_x_q;
    assign res_val    = res_val_q;
    assign ocupado    = (state_q != OCIOSO);
    assign terminou   = terminou_q;
    assign erro       = erro_q;
    assign contagem   = contagem_q;

endmodule

// File: tb/tb_host_polinomio.sv
// Directed bench for host_polinomio with a behavioural polynomial datapath on the far side.
module tb_host_polinomio;

    localparam int W = 16;

    logic         ck, rst, comeca, inicio, pronto, LED, res_valido, ocupado, terminou, erro;
    logic [W-1:0] x_ini, x_fim, a_in, b_in, c_in, X, A, B, C, Resultado, res_x, res_val;
    logic [W:0]   contagem;

    host_polinomio #(.W(W), .TIMEOUT(64)) dut (
        .ck(ck), .rst(rst), .comeca(comeca), .x_ini(x_ini), .x_fim(x_fim),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .inicio(inicio), .pronto(pronto),
        .X(X), .A(A), .B(B), .C(C), .Resultado(Resultado), .LED(LED),
        .res_valido(res_valido), .res_x(res_x), .res_val(res_val), .ocupado(ocupado),
        .terminou(terminou), .erro(erro), .contagem(contagem)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Behavioural datapath: LED rises n_lat cycles after inicio, falls on pronto
    int           n_lat = 3;
    bit           stuck = 1'b0;
    int           cnt_m;
    logic         led_m;
    logic [W-1:0] poly_m;

    always @(posedge ck or negedge rst) begin
        if (!rst) begin
            led_m <= 1'b0;
            cnt_m <= 0;
        end else if (pronto) begin
            led_m <= 1'b0;
            cnt_m <= 0;
        end else if (inicio && !stuck) begin
            cnt_m <= n_lat;
        end else if (cnt_m > 1) begin
            cnt_m <= cnt_m - 1;
        end else if (cnt_m == 1) begin
            led_m <= 1'b1;
            cnt_m <= 0;
        end
    end

    always_comb poly_m = A * X * X + B * X + C;
    assign LED       = led_m;
    assign Resultado = led_m ? poly_m : 16'h0000;

    // Observation of strobes on the falling edge
    int           n_inicio, n_pronto, n_term, n_consec;
    logic [W-1:0] q_val[$];
    logic [W-1:0] q_x[$];
    logic         p_ini, p_pro, p_rv, p_term;

    always @(negedge ck) begin
        if (rst) begin
            if (inicio) n_inicio++;
            if (pronto) n_pronto++;
            if (terminou) n_term++;
            if (res_valido) begin
                q_val.push_back(res_val);
                q_x.push_back(res_x);
            end
            if ((inicio && p_ini) || (pronto && p_pro) || (res_valido && p_rv) || (terminou && p_term))
                n_consec++;
        end
        p_ini  = inicio;
        p_pro  = pronto;
        p_rv   = res_valido;
        p_term = terminou;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic start_sweep(input logic [W-1:0] xi, xf, a, b, c);
        @(negedge ck);
        n_inicio = 0; n_pronto = 0; n_term = 0; n_consec = 0;
        q_val.delete();
        q_x.delete();
        x_ini = xi; x_fim = xf; a_in = a; b_in = b; c_in = c;
        comeca = 1'b1;
        @(negedge ck);
        comeca = 1'b0;
    endtask

    task automatic wait_term(input string tag);
        int k = 0;
        while (n_term == 0 && k < 2000) begin
            @(negedge ck);
            k++;
        end
        check_eq({tag, "_terminou"}, 32'(n_term), 32'd1);
        @(negedge ck);
    endtask

    task automatic check_results(input string tag, input int n, input logic [W-1:0] ev[4],
                                 input logic [W-1:0] x0);
        check_eq({tag, "_nres"}, 32'(q_val.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_val%0d", tag, i),
                     32'((i < q_val.size()) ? q_val[i] : 16'hDEAD), 32'(ev[i]));
            check_eq($sformatf("%s_x%0d", tag, i),
                     32'((i < q_x.size()) ? q_x[i] : 16'hDEAD), 32'(x0 + W'(i)));
        end
    endtask

    logic [W-1:0] ev[4];
    int           k;
    int           seen;

    initial begin
        rst = 1'b0; comeca = 1'b0;
        x_ini = '0; x_fim = '0; a_in = '0; b_in = '0; c_in = '0;
        n_inicio = 0; n_pronto = 0; n_term = 0; n_consec = 0;
        repeat (3) @(negedge ck);
        check_eq("rst_inicio", 32'(inicio), 32'd0);
        check_eq("rst_pronto", 32'(pronto), 32'd0);
        check_eq("rst_X", 32'(X), 32'd0);
        check_eq("rst_contagem", 32'(contagem), 32'd0);
        check_eq("rst_erro", 32'(erro), 32'd0);
        check_eq("rst_ocupado", 32'(ocupado), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge ck);

        // 1: single point x=2 -> 1*4 + 3*2 + 4 = 14
        start_sweep(16'd2, 16'd2, 16'd1, 16'd3, 16'd4);
        wait_term("c1");
        ev = '{16'd14, 16'd0, 16'd0, 16'd0};
        check_results("c1", 1, ev, 16'd2);
        check_eq("c1_inicio", 32'(n_inicio), 32'd1);
        check_eq("c1_contagem", 32'(contagem), 32'd1);
        check_eq("c1_erro", 32'(erro), 32'd0);
        check_eq("c1_ocupado", 32'(ocupado), 32'd0);

        // 2: sweep 0..3 -> 4, 8, 14, 22
        start_sweep(16'd0, 16'd3, 16'd1, 16'd3, 16'd4);
        wait_term("c2");
        ev = '{16'd4, 16'd8, 16'd14, 16'd22};
        check_results("c2", 4, ev, 16'd0);
        check_eq("c2_inicio", 32'(n_inicio), 32'd4);
        check_eq("c2_pronto", 32'(n_pronto), 32'd4);
        check_eq("c2_contagem", 32'(contagem), 32'd4);
        check_eq("c2_consec", 32'(n_consec), 32'd0);

        // 3: empty range, terminou two cycles after comeca
        @(negedge ck);
        n_inicio = 0; n_term = 0;
        x_ini = 16'd5; x_fim = 16'd2;
        comeca = 1'b1;
        @(negedge ck);
        comeca = 1'b0;
        check_eq("c3_term_early", 32'(terminou), 32'd0);
        @(negedge ck);
        check_eq("c3_term_at2", 32'(terminou), 32'd1);
        repeat (3) @(negedge ck);
        check_eq("c3_inicio", 32'(n_inicio), 32'd0);
        check_eq("c3_contagem", 32'(contagem), 32'd0);

        // 4: datapath never answers -> erro 64 cycles into ESPERA
        stuck = 1'b1;
        start_sweep(16'd7, 16'd7, 16'd1, 16'd1, 16'd1);
        k = 0;
        while (!inicio && k < 20) begin
            @(negedge ck);
            k++;
        end
        check_eq("c4_inicio_seen", 32'(inicio), 32'd1);
        k = 0;
        while (!erro && k < 200) begin
            @(negedge ck);
            k++;
        end
        check_eq("c4_erro_latency", 32'(k), 32'd65);
        wait_term("c4");
        check_eq("c4_erro", 32'(erro), 32'd1);
        check_eq("c4_pronto", 32'(n_pronto), 32'd1);
        check_eq("c4_nres", 32'(q_val.size()), 32'd0);
        check_eq("c4_contagem", 32'(contagem), 32'd0);
        stuck = 1'b0;

        // 5: top of range, no wrap of X; erro cleared by new sweep
        start_sweep(16'hFFFE, 16'hFFFF, 16'd0, 16'd1, 16'd0);
        check_eq("c5_erro_cleared", 32'(erro), 32'd0);
        wait_term("c5");
        ev = '{16'hFFFE, 16'hFFFF, 16'd0, 16'd0};
        check_results("c5", 2, ev, 16'hFFFE);
        check_eq("c5_X_nowrap", 32'(X), 32'h0000FFFF);
        check_eq("c5_contagem", 32'(contagem), 32'd2);
        check_eq("c5_inicio", 32'(n_inicio), 32'd2);

        // 6: asynchronous reset during ESPERA of the second point, then a clean sweep
        start_sweep(16'd0, 16'd3, 16'd1, 16'd3, 16'd4);
        seen = 0;
        k = 0;
        while (seen < 2 && k < 100) begin
            @(negedge ck);
            if (inicio) seen++;
            k++;
        end
        check_eq("c6_second_inicio", 32'(seen), 32'd2);
        @(negedge ck);
        #1 rst = 1'b0;
        #1;
        check_eq("c6_rst_ocupado", 32'(ocupado), 32'd0);
        check_eq("c6_rst_X", 32'(X), 32'd0);
        check_eq("c6_rst_A", 32'(A), 32'd0);
        check_eq("c6_rst_contagem", 32'(contagem), 32'd0);
        check_eq("c6_rst_inicio_pronto", 32'({inicio, pronto}), 32'd0);
        @(negedge ck);
        rst = 1'b1;
        @(negedge ck);
        start_sweep(16'd0, 16'd3, 16'd1, 16'd3, 16'd4);
        wait_term("c6");
        ev = '{16'd4, 16'd8, 16'd14, 16'd22};
        check_results("c6", 4, ev, 16'd0);
        check_eq("c6_contagem", 32'(contagem), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
